// File: rtl/port_arbiter_pkg.sv
// Shared definitions for the 4x4 FIFO switch arbiter: state encoding,
// default widths, threshold reset values and destination decode.
package port_arbiter_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_LIM_W  = 3;
    localparam int DEF_CNT_W  = 5;

    localparam logic [DEF_LIM_W-1:0] LIM_LOW_RST  = 3'd1;
    localparam logic [DEF_LIM_W-1:0] LIM_HIGH_RST = 3'd7;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    function automatic logic [3:0] dest_onehot(input logic [1:0] dest);
        logic [3:0] oh;
        case (dest)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// Data-path handshake between the arbiter (master) and the input/output
// FIFO bank (slave).
interface port_arbiter_if
    import port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [3:0]        in_empty;
    logic [DATA_W-1:0] data0_in;
    logic [DATA_W-1:0] data1_in;
    logic [DATA_W-1:0] data2_in;
    logic [DATA_W-1:0] data3_in;
    logic [3:0]        out_afull;
    logic [3:0]        in_pop;
    logic [3:0]        out_push;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  in_empty, data0_in, data1_in, data2_in, data3_in, out_afull,
        output in_pop, out_push, out_data
    );

    modport slave (
        output in_empty, data0_in, data1_in, data2_in, data3_in, out_afull,
        input  in_pop, out_push, out_data
    );

endinterface

// File: rtl/port_arbiter_rr_select.sv
// 4-way round-robin picker: grants the first requester after ptr_i,
// wrapping 3 -> 0. Purely combinational; the caller registers the result.
module port_arbiter_rr_select (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_vld_o
);

    logic [7:0] dbl_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;

    assign dbl_s = {req_i, req_i};
    assign rot_s = dbl_s[3'(ptr_i) + 3'd1 +: 4];

    // Priority-encode the request vector rotated to start just after ptr_i
    always_comb begin
        off_s     = 2'd0;
        gnt_vld_o = 1'b1;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: gnt_vld_o = 1'b0;
        endcase
    end

    assign gnt_idx_o = ptr_i + 2'd1 + off_s;
    assign gnt_o     = gnt_vld_o ? (4'b0001 << gnt_idx_o) : 4'b0000;

endmodule

// File: rtl/port_arbiter.sv
// Round-robin arbiter and configuration controller for the 4x4 FIFO switch:
// pops one input word per cycle, routes it by dest bits, owns thresholds and counters.
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LIM_W  = DEF_LIM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [LIM_W-1:0]  limit_low,
    input  logic [LIM_W-1:0]  limit_high,
    input  logic              req,
    input  logic [1:0]        idx,
    port_arbiter_if.master    bus,
    output logic [LIM_W-1:0]  lim_low_q,
    output logic [LIM_W-1:0]  lim_high_q,
    output logic [1:0]        state,
    output logic              idle,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  counter_out,
    output logic              counter_valid
);

    state_e            state_q;
    logic              idle_q;
    logic              cfg_err_q;
    logic [3:0]        req_vec_s;
    logic [3:0]        gnt_s;
    logic [1:0]        gnt_idx_s;
    logic              gnt_vld_s;
    logic [3:0]        in_pop_q;
    logic [1:0]        pop_idx_q;
    logic [1:0]        ptr_q;
    logic              s1_vld_q;
    logic [1:0]        s1_idx_q;
    logic [3:0]        out_push_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] sel_data_s;
    logic              pipe_empty_s;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  counter_out_q;
    logic              counter_valid_q;

    assign pipe_empty_s = (in_pop_q == 4'b0000) && !s1_vld_q;

    // Mode FSM; idle is registered alongside the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
            idle_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RST: begin
                    state_q <= init ? ST_INIT : ST_IDLE;
                    idle_q  <= !init;
                end
                ST_INIT: begin
                    state_q <= init ? ST_INIT : ST_IDLE;
                    idle_q  <= !init;
                end
                ST_IDLE: begin
                    if (init) begin
                        state_q <= ST_INIT;
                        idle_q  <= 1'b0;
                    end else if (bus.in_empty != 4'b1111) begin
                        state_q <= ST_ACTIVE;
                        idle_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if ((bus.in_empty == 4'b1111) && pipe_empty_s) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end else begin
                        state_q <= ST_ACTIVE;
                        idle_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RST;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

    // Any almost-full output freezes new pops; in-flight words still land
    always_comb begin
        if ((state_q == ST_ACTIVE) && (bus.out_afull == 4'b0000)) begin
            req_vec_s = ~bus.in_empty;
        end else begin
            req_vec_s = 4'b0000;
        end
    end

    port_arbiter_rr_select u_rr_select (
        .req_i     (req_vec_s),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    // Read-data mux for the input popped one cycle earlier
    always_comb begin
        case (s1_idx_q)
            2'd0:    sel_data_s = bus.data0_in;
            2'd1:    sel_data_s = bus.data1_in;
            2'd2:    sel_data_s = bus.data2_in;
            2'd3:    sel_data_s = bus.data3_in;
            default: sel_data_s = {DATA_W{1'b0}};
        endcase
    end

    // Pop -> capture -> push pipeline; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pop_q   <= 4'b0000;
            pop_idx_q  <= 2'd0;
            ptr_q      <= 2'd3;
            s1_vld_q   <= 1'b0;
            s1_idx_q   <= 2'd0;
            out_push_q <= 4'b0000;
            out_data_q <= {DATA_W{1'b0}};
        end else begin
            in_pop_q  <= gnt_s;
            pop_idx_q <= gnt_idx_s;
            if (gnt_vld_s) begin
                ptr_q <= gnt_idx_s;
            end
            s1_vld_q   <= (in_pop_q != 4'b0000);
            s1_idx_q   <= pop_idx_q;
            out_push_q <= s1_vld_q ? dest_onehot(sel_data_s[DATA_W-1 -: 2]) : 4'b0000;
            out_data_q <= s1_vld_q ? sel_data_s : {DATA_W{1'b0}};
        end
    end

    // Thresholds commit only when strictly ordered
    always_ff @(posedge clk) begin
        if (reset) begin
            lim_low_q  <= LIM_W'(LIM_LOW_RST);
            lim_high_q <= LIM_W'(LIM_HIGH_RST);
            cfg_err_q  <= 1'b0;
        end else if (state_q == ST_INIT) begin
            if (limit_low < limit_high) begin
                lim_low_q  <= limit_low;
                lim_high_q <= limit_high;
                cfg_err_q  <= 1'b0;
            end else begin
                cfg_err_q  <= 1'b1;
            end
        end
    end

    // Per-destination push counters, held at zero while configuring
    always_ff @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (reset || (state_q == ST_INIT)) begin
                cnt_q[d] <= {CNT_W{1'b0}};
            end else if (out_push_q[d]) begin
                cnt_q[d] <= cnt_q[d] + CNT_W'(1);
            end
        end
    end

    // Counter read-back returns the value before this cycle's push
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_out_q   <= {CNT_W{1'b0}};
            counter_valid_q <= 1'b0;
        end else if (req && (state_q != ST_RST)) begin
            counter_out_q   <= cnt_q[idx];
            counter_valid_q <= 1'b1;
        end else begin
            counter_valid_q <= 1'b0;
        end
    end

    assign bus.in_pop    = in_pop_q;
    assign bus.out_push  = out_push_q;
    assign bus.out_data  = out_data_q;
    assign state         = state_q;
    assign idle          = idle_q;
    assign cfg_err       = cfg_err_q;
    assign counter_out   = counter_out_q;
    assign counter_valid = counter_valid_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: bench-side input FIFO model plus
// hand-computed per-cycle expectations for pops, pushes, config and counters.
module tb_port_arbiter;
    import port_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    logic       init;
    logic [2:0] limit_low;
    logic [2:0] limit_high;
    logic       req;
    logic [1:0] idx;
    logic [2:0] lim_low_q;
    logic [2:0] lim_high_q;
    logic [1:0] state;
    logic       idle;
    logic       cfg_err;
    logic [4:0] counter_out;
    logic       counter_valid;

    int n_assert = 0;
    int n_fail   = 0;

    port_arbiter_if bus ();

    port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .limit_low     (limit_low),
        .limit_high    (limit_high),
        .req           (req),
        .idx           (idx),
        .bus           (bus),
        .lim_low_q     (lim_low_q),
        .lim_high_q    (lim_high_q),
        .state         (state),
        .idle          (idle),
        .cfg_err       (cfg_err),
        .counter_out   (counter_out),
        .counter_valid (counter_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input FIFO model: pop takes effect on the edge, data valid next cycle;
    // empty already accounts for a pop currently being requested.
    logic [9:0] fmem [4][64];
    int         wr_p [4];
    int         rd_p [4] = '{0, 0, 0, 0};
    logic [9:0] fdat [4] = '{10'd0, 10'd0, 10'd0, 10'd0};

    always_comb begin
        bus.in_empty = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.in_empty[i] = ((wr_p[i] - rd_p[i]) - (bus.in_pop[i] ? 1 : 0)) <= 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.in_pop[i] && (rd_p[i] < wr_p[i])) begin
                fdat[i] <= fmem[i][rd_p[i]];
                rd_p[i] <= rd_p[i] + 1;
            end
        end
    end

    assign bus.data0_in = fdat[0];
    assign bus.data1_in = fdat[1];
    assign bus.data2_in = fdat[2];
    assign bus.data3_in = fdat[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input int f, input logic [9:0] w);
        fmem[f][wr_p[f]] = w;
        wr_p[f] = wr_p[f] + 1;
    endtask

    logic [3:0] t3_pop  [7]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] t3_push [7]  = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    logic [9:0] t3_dat  [7]  = '{10'h0, 10'h0, 10'h0AA, 10'h155, 10'h2CC, 10'h333, 10'h0};
    logic [3:0] t4_pop  [13] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2,
                                 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
    logic [3:0] t4_push [13] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0,
                                 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    logic [9:0] t4_dat  [13] = '{10'h0, 10'h0, 10'h0, 10'h100, 10'h101, 10'h0, 10'h0,
                                 10'h0, 10'h102, 10'h103, 10'h104, 10'h105, 10'h0};
    logic [3:0] t4_afl  [13] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    initial begin
        int  pushes;
        bit  done;
        wr_p          = '{0, 0, 0, 0};
        reset         = 1'b1;
        init          = 1'b0;
        limit_low     = 3'd0;
        limit_high    = 3'd0;
        req           = 1'b0;
        idx           = 2'd0;
        bus.out_afull = 4'b0000;

        // Reset values
        repeat (3) step();
        check("rst_in_pop", bus.in_pop, 4'h0);
        check("rst_out_push", bus.out_push, 4'h0);
        check("rst_out_data", bus.out_data, 10'h0);
        check("rst_lim_low", lim_low_q, 3'd1);
        check("rst_lim_high", lim_high_q, 3'd7);
        check("rst_state", state, 2'd0);
        check("rst_idle", idle, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_cnt_out", counter_out, 5'd0);
        check("rst_cnt_vld", counter_valid, 1'b0);

        // Init with two good threshold pairs
        reset = 1'b0; init = 1'b1; limit_low = 3'd3; limit_high = 3'd6;
        step();
        check("init_state", state, 2'd1);
        step();
        check("init_lim_low_a", lim_low_q, 3'd3);
        check("init_lim_high_a", lim_high_q, 3'd6);
        limit_low = 3'd2; limit_high = 3'd7;
        step();
        check("init_lim_low_b", lim_low_q, 3'd2);
        check("init_lim_high_b", lim_high_q, 3'd7);
        check("init_cfg_err", cfg_err, 1'b0);
        init = 1'b0;
        step();
        check("init_exit_state", state, 2'd2);
        check("init_exit_idle", idle, 1'b1);

        // Rejected then accepted thresholds
        init = 1'b1; limit_low = 3'd5; limit_high = 3'd4;
        step();
        check("bad_state", state, 2'd1);
        step();
        check("bad_cfg_err", cfg_err, 1'b1);
        check("bad_lim_low", lim_low_q, 3'd2);
        check("bad_lim_high", lim_high_q, 3'd7);
        limit_low = 3'd1; limit_high = 3'd4;
        step();
        check("fix_cfg_err", cfg_err, 1'b0);
        check("fix_lim_low", lim_low_q, 3'd1);
        check("fix_lim_high", lim_high_q, 3'd4);
        init = 1'b0;
        step();
        check("fix_exit_state", state, 2'd2);

        // Round robin across all four inputs
        load(0, 10'h0AA); load(1, 10'h155); load(2, 10'h2CC); load(3, 10'h333);
        step();
        check("rr_state", state, 2'd3);
        check("rr_first_pop", bus.in_pop, 4'h0);
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("rr_pop%0d", k), bus.in_pop, t3_pop[k]);
            check($sformatf("rr_push%0d", k), bus.out_push, t3_push[k]);
            check($sformatf("rr_data%0d", k), bus.out_data, t3_dat[k]);
        end
        check("rr_idle_state", state, 2'd2);
        check("rr_idle", idle, 1'b1);
        req = 1'b1; idx = 2'd2;
        step();
        check("rr_cnt2", counter_out, 5'd1);
        check("rr_cnt2_vld", counter_valid, 1'b1);
        req = 1'b0;
        step();
        check("rr_cnt_vld_drop", counter_valid, 1'b0);

        // Stall on out_afull[1] with one busy input
        for (int k = 0; k < 6; k++) load(1, 10'(10'h100 + k));
        for (int k = 0; k < 13; k++) begin
            step();
            check($sformatf("st_pop%0d", k), bus.in_pop, t4_pop[k]);
            check($sformatf("st_push%0d", k), bus.out_push, t4_push[k]);
            check($sformatf("st_data%0d", k), bus.out_data, t4_dat[k]);
            bus.out_afull = t4_afl[k];
        end
        check("st_idle_state", state, 2'd2);
        req = 1'b1; idx = 2'd1;
        step();
        check("st_cnt1", counter_out, 5'd7);
        req = 1'b0;

        // Counter wrap: cnt[3] is 1, so 31 more pushes bring it to 0
        for (int k = 0; k < 31; k++) load(3, 10'(10'h300 + k));
        pushes = 0;
        done   = 1'b0;
        for (int c = 0; c < 120 && !done; c++) begin
            step();
            if (bus.out_push[3]) begin
                check($sformatf("wr_data%0d", pushes), bus.out_data, 32'h300 + 32'(pushes));
                pushes++;
            end
            if ((state == 2'd2) && (pushes >= 31)) done = 1'b1;
        end
        check("wr_pushes", pushes, 31);
        check("wr_state", state, 2'd2);
        check("wr_idle", idle, 1'b1);
        req = 1'b1; idx = 2'd3;
        step();
        check("wr_cnt3", counter_out, 5'd0);
        check("wr_cnt3_vld", counter_valid, 1'b1);
        req = 1'b0;

        // Reset in the cycle after a pop drops in-flight words
        load(0, 10'h200); load(0, 10'h201);
        step();
        check("mr_state", state, 2'd3);
        step();
        check("mr_pop_a", bus.in_pop, 4'h1);
        step();
        check("mr_pop_b", bus.in_pop, 4'h1);
        reset = 1'b1; req = 1'b1; idx = 2'd2;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("mr_push%0d", k), bus.out_push, 4'h0);
            check($sformatf("mr_vld%0d", k), counter_valid, 1'b0);
            check($sformatf("mr_state%0d", k), state, 2'd0);
        end
        reset = 1'b0; req = 1'b0;
        step();
        check("mr_exit_state", state, 2'd2);
        for (int d = 0; d < 4; d++) begin
            req = 1'b1; idx = 2'(d);
            step();
            check($sformatf("mr_cnt%0d", d), counter_out, 5'd0);
            check($sformatf("mr_cnt_vld%0d", d), counter_valid, 1'b1);
            check($sformatf("mr_nopush%0d", d), bus.out_push, 4'h0);
        end
        req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Round-robin arbiter and configuration controller for the 4-input / 4-output 10-bit FIFO switch. It pops words from the four input FIFOs one at a time and steers each word to the output FIFO selected by its destination field (bits [9:8]). It stalls the whole switch while any output FIFO is almost full. It also owns the almost-empty/almost-full thresholds, written during the init phase, and keeps per-destination word counters that can be read back with `req`/`idx`.

## Interface
- `DATA_W`, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination.
- `LIM_W`, 3, threshold width.
- `CNT_W`, 5, per-destination counter width.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `init` in 1: configuration phase request.
- `limit_low`, `limit_high` in LIM_W: threshold candidates, sampled during INIT.
- `in_empty` in 4: input FIFO empty flags (bit n = FIFO n).
- `data0_in`..`data3_in` in DATA_W: input FIFO read data, valid the cycle after the pop.
- `out_afull` in 4: output FIFO almost-full flags.
- `req` in 1, `idx` in 2: counter read request and destination index.
- `in_pop` out 4: one-hot or zero pop to the input FIFOs.
- `out_push` out 4: one-hot or zero push to the output FIFOs.
- `out_data` out DATA_W: shared write data for the output FIFOs.
- `lim_low_q`, `lim_high_q` out LIM_W: committed thresholds to all FIFOs.
- `state` out 2: current state.
- `idle` out 1: high in IDLE.
- `cfg_err` out 1: last threshold write was rejected.
- `counter_out` out CNT_W, `counter_valid` out 1: counter read result.

## Operation
- **States:** RST=0, INIT=1, IDLE=2, ACTIVE=3.
- **RST:** entered whenever `reset`=1.
  - Leaves next cycle to INIT if `init`=1, otherwise to IDLE.
- **INIT:** each cycle, if `limit_low` < `limit_high`, commit both values and clear `cfg_err`; otherwise keep the old values and set `cfg_err`=1.
  - Per-destination counters are held at 0.
  - `init`=0 moves to IDLE.
- **IDLE:**
  - `init`=1 moves to INIT; `init` has priority over data.
  - Else, if any `in_empty` bit is 0, move to ACTIVE.
- **ACTIVE:**
  - `init` is ignored.
  - Return to IDLE when all `in_empty`=1 and the pipeline is empty.
- **Grant rule (ACTIVE only):** pop only when `out_afull`==0.
  - Select the first non-empty input after the last granted input, wrapping 3→0; the round-robin pointer resets to 3, so input 0 goes first.
  - At most one pop per cycle; back-to-back pops of the same input are allowed when it is the only non-empty input.
- **Routing:** the popped word's bits [9:8] select the `out_push` bit.
  - `out_data` carries the word in that push cycle and is 0 otherwise.
- **Counters:** `cnt[d]` increments on each `out_push[d]` and wraps at 2^CNT_W.
- **Counter read:** `req`=1 in cycle N gives `counter_out`=`cnt[idx]` (value before any push in cycle N) and `counter_valid`=1 in cycle N+1. It works in every state except RST.

## Timing
- **Reset values:** `in_pop`=0, `out_push`=0, `out_data`=0, `lim_low_q`=1, `lim_high_q`=7, `state`=RST, `idle`=0, `cfg_err`=0, `counter_out`=0, `counter_valid`=0; all counters 0.
- **Pop-to-push latency:**
  - cycle N: pop asserted.
  - cycle N+1: data sampled from `dataG_in`.
  - cycle N+2: `out_push`/`out_data` registered outputs.
- **Throughput:** 1 word/cycle.
- **Stall:** an `out_afull` rise in cycle N blocks pops from cycle N. Up to 2 words already in flight still complete, so the output FIFOs must set `limit_high` ≤ depth−2.
- **Thresholds:** a committed threshold appears on `lim_*_q` the cycle after it is sampled.
- **Reset mid-operation:** in-flight words are dropped and no push follows the reset edge.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- **Shared package:** state encoding constants, `DATA_W`/`LIM_W`/`CNT_W` defaults, and the threshold reset values 1 and 7.
- **Sub-module `rr_select`:** a 4-way round-robin picker with request vector, pointer, grant one-hot, and grant index. The rest (FSM, 2-stage pipeline, counters, config registers) stays in `port_arbiter`.

## Test plan
1. **Reset:** hold `reset` 3 cycles → all outputs at reset values, `state`=0. Release with `init`=1, then drive limits 3/6 and 2/7, then drop `init` → `lim_low_q`/`lim_high_q` = 2/7, `state`=2, `cfg_err`=0.
2. **Bad thresholds:** `init`=1 with `limit_low`=5, `limit_high`=4 → `cfg_err`=1 and `lim_*_q` unchanged; a following 1/4 commits and clears `cfg_err`.
3. **Round robin and counters:** all four inputs non-empty with words 0x0AA, 0x155, 0x2CC, 0x333 → pops in order 0,1,2,3 on consecutive cycles; pushes on outputs 0,1,2,3 two cycles after each pop; then `req`,`idx`=2 → `counter_out`=1.
4. **Stall:** `out_afull`[1]=1 while input data is pending → `in_pop` goes 0 from that cycle, at most 2 further pushes, and popping resumes the cycle `out_afull` returns to 0.
5. **Counter wrap:** 32 words with dest 3 → `cnt[3]`=0. Inputs drain → `state` returns to 2 and `idle`=1 once the pipeline is empty.
6. **Reset mid-operation:** `reset` asserted in the cycle after a pop → no `out_push` follows and all counters read 0.
